// File: rtl/core_pkg.sv
// Shared types and widths for the RV64 (Zba) five-stage core.
// The ID/EX control bundle is a single struct so a bubble is one assignment.
package core_pkg;
  localparam int XLEN  = 64;
  localparam int REGW  = 5;
  localparam int ALUCW = 5;

  typedef enum logic [ALUCW-1:0] {
    ALU_ADD      = 5'd0,
    ALU_SUB      = 5'd1,
    ALU_AND      = 5'd2,
    ALU_OR       = 5'd3,
    ALU_XOR      = 5'd4,
    ALU_SLT      = 5'd5,
    ALU_SLTU     = 5'd6,
    ALU_SLL      = 5'd7,
    ALU_SRL      = 5'd8,
    ALU_SRA      = 5'd9,
    ALU_ADDW     = 5'd10,
    ALU_SUBW     = 5'd11,
    ALU_SLLW     = 5'd12,
    ALU_SRLW     = 5'd13,
    ALU_SRAW     = 5'd14,
    ALU_SH1ADD   = 5'd15,
    ALU_SH2ADD   = 5'd16,
    ALU_SH3ADD   = 5'd17,
    ALU_ADDUW    = 5'd18,
    ALU_SH1ADDUW = 5'd19,
    ALU_SH2ADDUW = 5'd20,
    ALU_SH3ADDUW = 5'd21,
    ALU_SLLIUW   = 5'd22
  } alu_op_e;

  typedef struct packed {
    logic    valid;
    logic    regWrite;
    logic    memToReg;
    logic    memWrite;
    logic    branch;
    logic    jump;
    logic    aluSrc;
    logic    word32;
    alu_op_e aluControl;
  } id_ex_ctrl_t;
endpackage

// File: rtl/operand_snoop.sv
// Picks the writeback value over a register operand when WB targets the same
// nonzero index; x0 never matches so its read value (0) survives.
module operand_snoop #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] idx,
  input  logic [XLEN-1:0] curVal,
  input  logic            regWriteW,
  input  logic [REGW-1:0] rdW,
  input  logic [XLEN-1:0] resultW,
  output logic [XLEN-1:0] selVal
);
  logic hit;

  assign hit    = regWriteW && (rdW != '0) && (rdW == idx);
  assign selVal = hit ? resultW : curVal;
endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with stall, flush-to-bubble and a
// writeback snoop that keeps captured or held operands current.
module id_ex_reg #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int REGW  = core_pkg::REGW,
  parameter int ALUCW = core_pkg::ALUCW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [REGW-1:0]  Rs1D,
  input  logic [REGW-1:0]  Rs2D,
  input  logic [REGW-1:0]  RdD,
  input  logic             RegWriteD,
  input  logic             MemToRegD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             ALUSrcD,
  input  logic             Word32D,
  input  logic [ALUCW-1:0] ALUControlD,
  input  logic             RegWriteW,
  input  logic [REGW-1:0]  RdW,
  input  logic [XLEN-1:0]  ResultW,
  output logic             ValidE,
  output logic             RegWriteE,
  output logic             MemToRegE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             JumpE,
  output logic             ALUSrcE,
  output logic             Word32E,
  output logic [ALUCW-1:0] ALUControlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [REGW-1:0]  Rs1E,
  output logic [REGW-1:0]  Rs2E,
  output logic [REGW-1:0]  RdE
);
  import core_pkg::*;

  localparam int NOPS = 2;

  id_ex_ctrl_t                       ctrlD, ctrlE;
  logic [NOPS-1:0][REGW-1:0]         rsD, rsE, snoopIdx;
  logic [NOPS-1:0][XLEN-1:0]         rdD, rdE, snoopCur, snoopVal;
  logic [REGW-1:0]                   rdIdxE;
  logic [XLEN-1:0]                   pcE, pc4E, immE;

  assign rsD = {Rs2D, Rs1D};
  assign rdD = {RD2D, RD1D};

  // Invalid slots drop every side-effecting control at capture.
  always_comb begin
    ctrlD            = '0;
    ctrlD.valid      = ValidD;
    ctrlD.regWrite   = RegWriteD & ValidD;
    ctrlD.memToReg   = MemToRegD;
    ctrlD.memWrite   = MemWriteD & ValidD;
    ctrlD.branch     = BranchD & ValidD;
    ctrlD.jump       = JumpD & ValidD;
    ctrlD.aluSrc     = ALUSrcD;
    ctrlD.word32     = Word32D;
    ctrlD.aluControl = alu_op_e'(ALUControlD);
  end

  // One snoop per operand: on stall it watches the held E index, else D.
  for (genvar i = 0; i < NOPS; i++) begin : g_op
    assign snoopIdx[i] = StallE ? rsE[i] : rsD[i];
    assign snoopCur[i] = StallE ? rdE[i] : rdD[i];

    operand_snoop #(.XLEN(XLEN), .REGW(REGW)) u_snoop (
      .idx      (snoopIdx[i]),
      .curVal   (snoopCur[i]),
      .regWriteW(RegWriteW),
      .rdW      (RdW),
      .resultW  (ResultW),
      .selVal   (snoopVal[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ctrlE  <= '0;
      rsE    <= '0;
      rdE    <= '0;
      rdIdxE <= '0;
      pcE    <= '0;
      pc4E   <= '0;
      immE   <= '0;
    end else if (StallE) begin
      rdE <= snoopVal;
    end else begin
      ctrlE  <= ctrlD;
      rsE    <= rsD;
      rdE    <= snoopVal;
      rdIdxE <= RdD;
      pcE    <= PCD;
      pc4E   <= PCPlus4D;
      immE   <= ImmExtD;
    end
  end

  assign ValidE      = ctrlE.valid;
  assign RegWriteE   = ctrlE.regWrite;
  assign MemToRegE   = ctrlE.memToReg;
  assign MemWriteE   = ctrlE.memWrite;
  assign BranchE     = ctrlE.branch;
  assign JumpE       = ctrlE.jump;
  assign ALUSrcE     = ctrlE.aluSrc;
  assign Word32E     = ctrlE.word32;
  assign ALUControlE = ALUCW'(ctrlE.aluControl);
  assign RD1E        = rdE[0];
  assign RD2E        = rdE[1];
  assign Rs1E        = rsE[0];
  assign Rs2E        = rsE[1];
  assign RdE         = rdIdxE;
  assign PCE         = pcE;
  assign PCPlus4E    = pc4E;
  assign ImmExtE     = immE;
endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a reference model pushes the expected E
// state each cycle; it is popped and compared one edge later.
module tb_id_ex_reg;
  import core_pkg::*;

  typedef struct packed {
    logic        valid, regWrite, memToReg, memWrite, branch, jump, aluSrc, word32;
    logic [4:0]  aluc;
    logic [63:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  logic        clk = 1'b0, reset;
  logic        StallE, FlushE, ValidD;
  logic [63:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD, RdW, ALUControlD;
  logic        RegWriteD, MemToRegD, MemWriteD, BranchD, JumpD, ALUSrcD, Word32D, RegWriteW;
  logic        ValidE, RegWriteE, MemToRegE, MemWriteE, BranchE, JumpE, ALUSrcE, Word32E;
  logic [4:0]  ALUControlE, Rs1E, Rs2E, RdE;
  logic [63:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;

  int   checks = 0, errors = 0;
  exp_t m = '0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .JumpD(JumpD), .ALUSrcD(ALUSrcD), .Word32D(Word32D),
    .ALUControlD(ALUControlD), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE), .Word32E(Word32E),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic wHit(input logic [4:0] idx);
    return RegWriteW && RdW != 5'd0 && RdW == idx;
  endfunction

  // Reference model of one edge, then compare the popped expectation.
  task automatic step();
    exp_t n, e;
    if (reset || FlushE) n = '0;
    else if (StallE) begin
      n = m;
      if (wHit(m.rs1)) n.rd1 = ResultW;
      if (wHit(m.rs2)) n.rd2 = ResultW;
    end else begin
      n.valid    = ValidD;
      n.regWrite = ValidD ? RegWriteD : 1'b0;
      n.memWrite = ValidD ? MemWriteD : 1'b0;
      n.branch   = ValidD ? BranchD : 1'b0;
      n.jump     = ValidD ? JumpD : 1'b0;
      n.memToReg = MemToRegD;
      n.aluSrc   = ALUSrcD;
      n.word32   = Word32D;
      n.aluc     = ALUControlD;
      n.rd1      = wHit(Rs1D) ? ResultW : RD1D;
      n.rd2      = wHit(Rs2D) ? ResultW : RD2D;
      n.pc = PCD; n.pc4 = PCPlus4D; n.imm = ImmExtD;
      n.rs1 = Rs1D; n.rs2 = Rs2D; n.rd = RdD;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ValidE", 64'(ValidE), 64'(e.valid));
    chk("RegWriteE", 64'(RegWriteE), 64'(e.regWrite));
    chk("MemToRegE", 64'(MemToRegE), 64'(e.memToReg));
    chk("MemWriteE", 64'(MemWriteE), 64'(e.memWrite));
    chk("BranchE", 64'(BranchE), 64'(e.branch));
    chk("JumpE", 64'(JumpE), 64'(e.jump));
    chk("ALUSrcE", 64'(ALUSrcE), 64'(e.aluSrc));
    chk("Word32E", 64'(Word32E), 64'(e.word32));
    chk("ALUControlE", 64'(ALUControlE), 64'(e.aluc));
    chk("RD1E", RD1E, e.rd1);
    chk("RD2E", RD2E, e.rd2);
    chk("PCE", PCE, e.pc);
    chk("PCPlus4E", PCPlus4E, e.pc4);
    chk("ImmExtE", ImmExtE, e.imm);
    chk("Rs1E", 64'(Rs1E), 64'(e.rs1));
    chk("Rs2E", 64'(Rs2E), 64'(e.rs2));
    chk("RdE", 64'(RdE), 64'(e.rd));
  endtask

  task automatic setD(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2);
    ValidD = v; Rs1D = r1; Rs2D = r2; RdD = rd; RD1D = d1; RD2D = d2;
  endtask

  task automatic clrW();
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 64'd0;
  endtask

  initial begin
    // Reset with every D input nonzero.
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    setD(1'b1, 5'd1, 5'd2, 5'd3, 64'hDEAD, 64'hBEEF);
    PCD = 64'h100; PCPlus4D = 64'h104; ImmExtD = 64'h7;
    RegWriteD = 1'b1; MemToRegD = 1'b1; MemWriteD = 1'b1; BranchD = 1'b1;
    JumpD = 1'b1; ALUSrcD = 1'b1; Word32D = 1'b1; ALUControlD = 5'd9;
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 64'h55;
    step();
    chk("rst_ValidE", 64'(ValidE), 64'd0);
    chk("rst_PCE", PCE, 64'd0);
    reset = 1'b0; clrW();

    // Plain capture.
    setD(1'b1, 5'd3, 5'd4, 5'd5, 64'h1111, 64'h2222);
    RegWriteD = 1'b1; MemWriteD = 1'b0; BranchD = 1'b0; JumpD = 1'b0;
    ALUControlD = 5'(ALU_SH2ADD);
    step();
    chk("cap_RD1E", RD1E, 64'h1111);
    chk("cap_ALUC", 64'(ALUControlE), 64'(ALU_SH2ADD));

    // Write-first bypass, then x0 with RdW = 0.
    setD(1'b1, 5'd7, 5'd8, 5'd5, 64'hAAAA, 64'h2222);
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 64'hBEEF;
    step();
    chk("byp_RD1E", RD1E, 64'hBEEF);
    chk("byp_RD2E", RD2E, 64'h2222);
    setD(1'b1, 5'd0, 5'd8, 5'd5, 64'hAAAA, 64'h2222);
    RdW = 5'd0;
    step();
    chk("x0_RD1E", RD1E, 64'hAAAA);
    clrW();

    // Stalled snoop on Rs2E.
    setD(1'b1, 5'd6, 5'd9, 5'd5, 64'h3, 64'h5);
    step();
    StallE = 1'b1;
    setD(1'b1, 5'd12, 5'd13, 5'd14, 64'hF0, 64'hF1);
    PCD = 64'h900;
    step();
    RegWriteW = 1'b1; RdW = 5'd9; ResultW = 64'h1234;
    step();
    chk("stl_RD2E", RD2E, 64'h1234);
    clrW();
    step();
    chk("stl_hold_RD2E", RD2E, 64'h1234);
    chk("stl_hold_RD1E", RD1E, 64'h3);

    // Flush wins over stall.
    FlushE = 1'b1;
    step();
    chk("fl_ValidE", 64'(ValidE), 64'd0);
    chk("fl_Rs2E", 64'(Rs2E), 64'd0);
    FlushE = 1'b0; StallE = 1'b0;

    // Invalid slot suppresses side effects but still captures PC.
    setD(1'b0, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22);
    RegWriteD = 1'b1; MemWriteD = 1'b1; JumpD = 1'b1; BranchD = 1'b1; PCD = 64'h4000;
    step();
    chk("inv_RegWriteE", 64'(RegWriteE), 64'd0);
    chk("inv_JumpE", 64'(JumpE), 64'd0);
    chk("inv_PCE", PCE, 64'h4000);

    // Both operands on the same producer.
    setD(1'b1, 5'd10, 5'd10, 5'd3, 64'h1, 64'h2);
    RegWriteW = 1'b1; RdW = 5'd10; ResultW = 64'hCAFE;
    step();
    chk("both_RD2E", RD2E, 64'hCAFE);
    clrW();

    // Reset mid-stall discards the held instruction.
    StallE = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; StallE = 1'b0;
    setD(1'b1, 5'd2, 5'd3, 5'd4, 64'h77, 64'h88);
    step();

    // Randomized traffic; small index range to provoke snoop hits.
    for (int i = 0; i < 300; i++) begin
      reset  = ($urandom_range(0, 49) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      StallE = ($urandom_range(0, 3) == 0);
      setD(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      PCD = {$urandom, $urandom}; PCPlus4D = {$urandom, $urandom}; ImmExtD = {$urandom, $urandom};
      {RegWriteD, MemToRegD, MemWriteD, BranchD, JumpD, ALUSrcD, Word32D} = 7'($urandom);
      ALUControlD = 5'($urandom_range(0, 22));
      RegWriteW = 1'($urandom); RdW = 5'($urandom_range(0, 3)); ResultW = {$urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Decode-to-execute pipeline register for the RV64 (Zba) five-stage core.
- Captures decoded control, register operands, immediate and PC from decode, and presents the E-stage copies.
- Those copies drive the execute-stage forwarding muxes (RD1E/RD2E into the SrcA/SrcB selectors; Rs1E/Rs2E into the hazard unit).
- Supports stall and flush (bubble insertion).
- Snoops the writeback bus so that held or freshly captured operands are never stale once the producer leaves the forwarding window.

Parameters:
- XLEN, 64, datapath width.
- REGW, 5, register index width.
- ALUCW, 5, ALU control width (base ops plus sh1add/sh2add/sh3add/add.uw and .uw variants).

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- StallE  in  1  hold all E-stage contents
- FlushE  in  1  replace E-stage contents with a bubble
- ValidD  in  1  decode slot holds a real instruction
- RD1D, RD2D  in  XLEN  register file read data
- PCD, PCPlus4D, ImmExtD  in  XLEN  PC, PC+4, extended immediate
- Rs1D, Rs2D, RdD  in  REGW  source and destination indices
- RegWriteD, MemToRegD, MemWriteD, BranchD, JumpD, ALUSrcD, Word32D  in  1 each  decoded controls
- ALUControlD  in  ALUCW  ALU operation
- RegWriteW  in  1  writeback enable
- RdW  in  REGW  writeback destination
- ResultW  in  XLEN  writeback value
- ValidE, RegWriteE, MemToRegE, MemWriteE, BranchE, JumpE, ALUSrcE, Word32E  out  1 each  registered controls
- ALUControlE  out  ALUCW  registered ALU operation
- RD1E, RD2E, PCE, PCPlus4E, ImmExtE  out  XLEN  registered data
- Rs1E, Rs2E, RdE  out  REGW  registered indices

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high. All state updates on the rising edge only.
- Update priority each edge: reset > FlushE > StallE > capture.
- Reset: every output is 0, including ValidE and all indices. The E stage then looks like a bubble with Rs = x0, so the hazard unit generates no forwarding.
- FlushE = 1: same all-zero bubble as reset. Flush wins over a simultaneous StallE.
- StallE = 1, FlushE = 0:
  - All fields hold.
  - Exception (snoop): if RegWriteW = 1, RdW != 0 and RdW == Rs1E, then RD1E <= ResultW. Same rule for Rs2E/RD2E.
  - This covers a producer that retires from WB while the consumer is held, which the forwarding mux can no longer see.
- Capture (StallE = 0, FlushE = 0):
  - Every E output takes its D counterpart after 1 cycle.
  - Write-first bypass: if RegWriteW = 1, RdW != 0 and RdW == Rs1D, then RD1E <= ResultW instead of RD1D. Same rule for Rs2D/RD2D.
  - Captured unconditionally, independent of ValidD.
- ValidD = 0 on capture:
  - ValidE = 0 and RegWriteE = MemWriteE = BranchE = JumpE = 0. All other fields are captured as-is.
  - Invariant: an invalid E slot never writes, stores or redirects.
- x0 rule: an index of 0 never matches a snoop. RD1E/RD2E for x0 keep the value read from the register file, which is 0.
- Both operands matching the same RdW: both update in the same cycle.
- No combinational path from any input to any output. Latency is exactly 1 cycle.
- Reset asserted mid-stall: the held instruction is discarded. The first edge with reset deasserted captures D normally.

Decomposition:
- Shared package core_pkg:
  - XLEN and REGW constants.
  - alu_op_e enum of width ALUCW, including the Zba encodings.
  - An id_ex_ctrl_t packed struct grouping the 1-bit controls plus ALUControl, so that flush and reset clear it in a single assignment.
- One natural sub-module, operand_snoop:
  - Parameterised on XLEN/REGW.
  - Inputs: index, current value, RegWriteW, RdW, ResultW.
  - Output: the selected value.
  - Instantiated twice for capture (on D fields) and twice for hold (on E fields), or once per operand with a stall-selected index.

Test Plan:
- Reset: assert reset 1 cycle with all D inputs nonzero -> every E output = 0, ValidE = 0.
- Capture: RD1D = 0x1111, RD2D = 0x2222, Rs1D = 3, Rs2D = 4, RdD = 5, ALUControlD = sh2add, ValidD = 1, no stall/flush -> next cycle E fields equal the D values exactly, ValidE = 1.
- Write-first bypass: Rs1D = 7, RD1D = 0xAAAA, RegWriteW = 1, RdW = 7, ResultW = 0xBEEF -> RD1E = 0xBEEF, RD2E unchanged from RD2D. Repeat with RdW = 0 and Rs1D = 0 -> RD1E = RD1D.
- Stalled snoop: E holds Rs2E = 9, RD2E = 0x5. StallE = 1 for 3 cycles; in cycle 2 drive RegWriteW = 1, RdW = 9, ResultW = 0x1234 -> RD2E = 0x1234 from the next edge, held through the stall, all other fields unchanged.
- Flush vs stall: StallE = 1 and FlushE = 1 together with a valid instruction in E -> bubble: ValidE = 0, RegWriteE = 0, Rs1E = Rs2E = 0, RD1E = 0.
- Invalid slot: ValidD = 0 with RegWriteD = MemWriteD = JumpD = 1 -> ValidE = 0, RegWriteE = MemWriteE = JumpE = 0, PCE still captured.
